// File: rtl/fault_campaign_controller.sv
// Sweeps a burst-error injector over a fixed 49-case campaign (baseline plus 4x12 bursts)
// and tallies checker verdicts, keeping sticky status and the first undetected case.
module fault_campaign_controller #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] fault_start_addr,
  output logic [1:0] burst_error_length,
  output logic       fault_en,
  output logic       chk_req,
  input  logic       chk_valid,
  input  logic       chk_err,
  output logic       busy,
  output logic       done,
  output logic [5:0] detect_cnt,
  output logic [5:0] miss_cnt,
  output logic       false_alarm,
  output logic       timeout_err,
  output logic       aborted,
  output logic [3:0] first_miss_addr,
  output logic [1:0] first_miss_len,
  output logic       miss_seen
);

  typedef enum logic [1:0] {IDLE, APPLY, WAIT, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [5:0] LAST_CASE    = 6'd48;

  state_t     state, state_nxt;
  logic [5:0] case_idx;
  logic [3:0] cur_addr;
  logic [1:0] cur_len;
  logic [3:0] settle_cnt;
  logic [7:0] wait_cnt;
  logic       record;
  logic       active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    record    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = APPLY;
      APPLY: begin
        if (abort)                          state_nxt = DONE;
        else if (settle_cnt == SETTLE_LAST) state_nxt = WAIT;
      end
      WAIT: begin
        // abort outranks a coincident verdict, which is then dropped
        if (abort) state_nxt = DONE;
        else if (chk_valid) begin
          record    = 1'b1;
          state_nxt = (case_idx == LAST_CASE) ? DONE : APPLY;
        end else if (wait_cnt == TIMEOUT_LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign active             = (state == APPLY) || (state == WAIT);
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
  assign chk_req            = (state == APPLY) && (settle_cnt == SETTLE_LAST);
  assign fault_en           = active && (case_idx != 6'd0);
  assign fault_start_addr   = active ? cur_addr : '0;
  assign burst_error_length = active ? cur_len  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      case_idx        <= '0;
      cur_addr        <= '0;
      cur_len         <= '0;
      settle_cnt      <= '0;
      wait_cnt        <= '0;
      detect_cnt      <= '0;
      miss_cnt        <= '0;
      false_alarm     <= 1'b0;
      timeout_err     <= 1'b0;
      aborted         <= 1'b0;
      first_miss_addr <= '0;
      first_miss_len  <= '0;
      miss_seen       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          case_idx        <= '0;
          cur_addr        <= '0;
          cur_len         <= '0;
          settle_cnt      <= '0;
          detect_cnt      <= '0;
          miss_cnt        <= '0;
          false_alarm     <= 1'b0;
          timeout_err     <= 1'b0;
          aborted         <= 1'b0;
          first_miss_addr <= '0;
          first_miss_len  <= '0;
          miss_seen       <= 1'b0;
        end
        APPLY: begin
          settle_cnt <= settle_cnt + 4'd1;
          wait_cnt   <= '0;
          if (abort) aborted <= 1'b1;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (abort) aborted <= 1'b1;
          else if (record) begin
            if (case_idx == 6'd0) begin
              if (chk_err) false_alarm <= 1'b1;
            end else if (chk_err) begin
              detect_cnt <= detect_cnt + 6'd1;
            end else begin
              miss_cnt <= miss_cnt + 6'd1;
              if (!miss_seen) begin
                miss_seen       <= 1'b1;
                first_miss_addr <= cur_addr;
                first_miss_len  <= cur_len;
              end
            end
            if (case_idx != LAST_CASE) begin
              case_idx   <= case_idx + 6'd1;
              settle_cnt <= '0;
              // baseline and case 1 share coordinates (0,0), so only step after case 1 onwards
              if (case_idx != 6'd0) begin
                if (cur_addr == 4'd11) begin
                  cur_addr <= '0;
                  cur_len  <= cur_len + 2'd1;
                end else begin
                  cur_addr <= cur_addr + 4'd1;
                end
              end
            end
          end else if (!chk_valid && wait_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fault_campaign_controller.md
FAULT_CAMPAIGN_CONTROLLER -- requirements
Module: fault_campaign_controller

Interface
REQ-001 Parameter SETTLE, default 2: cycles that injector inputs are held stable before a check request is issued (legal range 1..15).
REQ-002 Parameter TIMEOUT, default 64: maximum wait cycles for checker response after chk_req (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin campaign; honoured only in IDLE.
REQ-006 abort  input  1  terminate campaign; honoured in any non-IDLE state.
REQ-007 fault_start_addr  output  4  injector start bit, 0..11.
REQ-008 burst_error_length  output  2  injector burst code, 0 = 1 bit .. 3 = 4 bits.
REQ-009 fault_en  output  1  injector enable.
REQ-010 chk_req  output  1  one-cycle pulse requesting a checker verdict on the corrupted codeword.
REQ-011 chk_valid  input  1  checker verdict valid.
REQ-012 chk_err  input  1  checker flagged an error; qualified by chk_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on campaign end (normal, abort or timeout).
REQ-015 detect_cnt, miss_cnt  output  6 each  detected / undetected injected cases.
REQ-016 false_alarm, timeout_err, aborted  output  1 each  sticky status flags for the last campaign.
REQ-017 first_miss_addr  output  4 ; first_miss_len  output  2 ; miss_seen  output  1  coordinates of the first undetected case.

Function
REQ-018 FSM states: IDLE, APPLY, WAIT, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-019 Campaign = 49 cases: case 0 is a baseline with fault_en=0, addr=0, len=0; cases 1..48 sweep burst_error_length 0..3 (outer) by fault_start_addr 0..11 (inner), all with fault_en=1.
REQ-020 IDLE with start=1 -> APPLY next cycle; all counters, flags and first-miss fields are cleared on that edge; case index = 0.
REQ-021 APPLY holds for SETTLE cycles; chk_req pulses on the last APPLY cycle; the FSM then enters WAIT.
REQ-022 fault_en, fault_start_addr and burst_error_length stay stable from APPLY entry until WAIT exit; outside APPLY/WAIT fault_en=0 and addr/len=0.
REQ-023 In WAIT, chk_valid=1 records the verdict on that edge: for case 0, chk_err=1 sets false_alarm; for cases 1..48, chk_err=1 increments detect_cnt, chk_err=0 increments miss_cnt.
REQ-024 On the first miss, first_miss_addr/len capture the current case and miss_seen is set; later misses do not overwrite them.
REQ-025 After recording, case 48 -> DONE; any other case -> APPLY with the next case.
REQ-026 chk_valid is ignored outside WAIT, including during the chk_req cycle.
REQ-027 If WAIT lasts TIMEOUT cycles without chk_valid, set timeout_err and go to DONE; the pending case is not counted.
REQ-028 abort in APPLY/WAIT -> DONE next cycle and sets aborted; abort wins over a coincident chk_valid, which is then not counted.
REQ-029 start outside IDLE is ignored; abort in IDLE is ignored; start and abort together in IDLE -> campaign starts.
REQ-030 Edge cases with bursts past bit 11 (e.g. addr 10, len 3) are still applied and counted normally; detect_cnt + miss_cnt never exceeds 48.
REQ-031 Results hold after DONE until the next accepted start.

Reset
REQ-032 rst_n=0 immediately forces IDLE; busy, done, chk_req, fault_en=0; addr/len=0; all counters, flags and first-miss fields=0.
REQ-033 Reset mid-campaign discards all partial results; no done pulse is issued.

Verification
REQ-034 Responder returns chk_valid=1, chk_err=1 one cycle after every chk_req; except baseline chk_err=0 -> detect_cnt=48, miss_cnt=0, false_alarm=0, single done pulse.
REQ-035 Responder returns chk_err=0 only for len=3 at addr 5 and addr 9 -> miss_cnt=2, detect_cnt=46, first_miss_addr=5, first_miss_len=3, miss_seen=1.
REQ-036 Baseline returns chk_err=1 -> false_alarm=1; counts are unaffected.
REQ-037 Responder goes silent at case 10 -> timeout_err=1 after 64 WAIT cycles, detect_cnt=9, done pulse, then fault_en=0.
REQ-038 abort asserted in the same cycle as chk_valid in case 20 -> aborted=1, detect_cnt=19, done the next cycle; a later start clears all results.
REQ-039 rst_n pulsed low in WAIT of case 30 -> all outputs 0 asynchronously, no done; a fresh start then completes a full 49-case campaign.
